// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
// Both the RTL and anything that talks to it import these definitions.
package muldiv_unit_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int ITERS  = 8;

    typedef enum logic [1:0] {
        MUL_LO = 2'b00,
        MUL_HI = 2'b01,
        DIV_Q  = 2'b10,
        DIV_R  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic isDiv(op_e o);
        return (o == DIV_Q) || (o == DIV_R);
    endfunction

    // MUL_HI and DIV_R both read the upper byte of the shared accumulator.
    function automatic logic selectsHigh(op_e o);
        return (o == MUL_HI) || (o == DIV_R);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 8-bit unsigned multiply/divide unit writing one result byte back to the register file.
// A single 16-bit accumulator performs shift-add multiply or restoring divide, one bit per cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [ADDR_W-1:0] dest_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              wb_enable,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              div_by_zero
);

    state_e              state_q, state_d;
    logic [3:0]          iterCnt_q, iterCnt_d;
    op_e                 opCode_q, opCode_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic [ADDR_W-1:0]   destAddr_q, destAddr_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic [DATA_W:0]     mulSum;
    logic [DATA_W:0]     divTrial;
    logic [DATA_W:0]     divDiff;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            iterCnt_q  <= '0;
            opCode_q   <= MUL_LO;
            divisor_q  <= '0;
            destAddr_q <= '0;
            acc_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            iterCnt_q  <= iterCnt_d;
            opCode_q   <= opCode_d;
            divisor_q  <= divisor_d;
            destAddr_q <= destAddr_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
        end
    end

    // Multiply adds the multiplier into the high byte then shifts right; divide shifts
    // left and subtracts when the partial remainder covers the divisor. A zero divisor
    // always "fits", which yields quotient 0xFF and remainder = dividend with no special case.
    always_comb begin
        state_d    = state_q;
        iterCnt_d  = iterCnt_q;
        opCode_d   = opCode_q;
        divisor_d  = divisor_q;
        destAddr_d = destAddr_q;
        acc_d      = acc_q;
        result_d   = result_q;

        mulSum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
        divTrial = acc_q[2*DATA_W-1:DATA_W-1];
        divDiff  = divTrial - {1'b0, divisor_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    opCode_d   = op_e'(op);
                    divisor_d  = operand_b;
                    destAddr_d = dest_addr;
                    acc_d      = {{DATA_W{1'b0}}, operand_a};
                    iterCnt_d  = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (isDiv(opCode_q)) begin
                    if (divTrial >= {1'b0, divisor_q}) begin
                        acc_d = {divDiff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mulSum, acc_q[DATA_W-1:1]};
                end
                iterCnt_d = iterCnt_q + 4'd1;
                if (iterCnt_q == 4'(ITERS - 1)) begin
                    state_d  = DONE;
                    result_d = selectsHigh(opCode_q) ? acc_d[2*DATA_W-1:DATA_W]
                                                     : acc_d[DATA_W-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign wb_addr     = destAddr_q;
    assign wb_enable   = done && (destAddr_q != '0);
    assign div_by_zero = done && isDiv(opCode_q) && (divisor_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [2:0] dest_addr;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       wb_enable;
    logic [2:0] wb_addr;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .dest_addr  (dest_addr),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .wb_enable  (wb_enable),
        .wb_addr    (wb_addr),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] refModel(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        int prod;
        prod = int'(a) * int'(b);
        case (o)
            2'b00:   return 8'(prod % 256);
            2'b01:   return 8'(prod / 256);
            2'b10:   return (b == 0) ? 8'hFF : 8'(int'(a) / int'(b));
            default: return (b == 0) ? a : 8'(int'(a) % int'(b));
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic scrambleInputs();
        op        = 2'($urandom);
        operand_a = 8'($urandom);
        operand_b = 8'($urandom);
        dest_addr = 3'($urandom);
    endtask

    // Called at a falling edge; leaves the bench at the falling edge of cycle N+10.
    task automatic applyStimulus(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] d, input bit pulseAgain);
        logic [7:0] expResult;
        expResult = refModel(o, a, b);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        dest_addr = d;
        @(negedge clk);
        start = 1'b0;
        scrambleInputs();
        for (int i = 1; i <= 10; i++) begin
            checkOutput($sformatf("busy@N+%0d", i), 16'(busy), 16'(i <= 9));
            checkOutput($sformatf("done@N+%0d", i), 16'(done), 16'(i == 9));
            if (i == 9) begin
                checkOutput("result", 16'(result), 16'(expResult));
                checkOutput("wb_enable", 16'(wb_enable), 16'(d != 0));
                checkOutput("wb_addr", 16'(wb_addr), 16'(d));
                checkOutput("div_by_zero", 16'(div_by_zero), 16'(o[1] && (b == 0)));
            end else begin
                checkOutput($sformatf("wb_enable_low@N+%0d", i), 16'(wb_enable), 16'd0);
                checkOutput($sformatf("dbz_low@N+%0d", i), 16'(div_by_zero), 16'd0);
            end
            if (i == 10) begin
                checkOutput("result_hold", 16'(result), 16'(expResult));
            end else begin
                scrambleInputs();
                start = pulseAgain && (i == 3);
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        $display("[TB] starting muldiv_unit bench");
        reset = 1'b1;
        start = 1'b0;
        op = 2'b00;
        operand_a = 8'h00;
        operand_b = 8'h00;
        dest_addr = 3'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_done", 16'(done), 16'd0);
        checkOutput("rst_result", 16'(result), 16'h00);
        checkOutput("rst_wb_enable", 16'(wb_enable), 16'd0);
        checkOutput("rst_wb_addr", 16'(wb_addr), 16'd0);
        checkOutput("rst_dbz", 16'(div_by_zero), 16'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        op = 2'b00;
        operand_a = 8'd9;
        operand_b = 8'd9;
        dest_addr = 3'd2;
        @(negedge clk);
        start = 1'b0;
        checkOutput("rst_over_start_busy", 16'(busy), 16'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(2'b00, 8'd13, 8'd11, 3'd3, 1'b0);
        applyStimulus(2'b01, 8'd13, 8'd11, 3'd3, 1'b0);
        applyStimulus(2'b01, 8'hFF, 8'hFF, 3'd1, 1'b0);
        applyStimulus(2'b00, 8'hFF, 8'hFF, 3'd7, 1'b0);
        applyStimulus(2'b10, 8'd200, 8'd7, 3'd4, 1'b0);
        applyStimulus(2'b11, 8'd200, 8'd7, 3'd4, 1'b0);
        applyStimulus(2'b10, 8'h55, 8'h00, 3'd5, 1'b0);
        applyStimulus(2'b11, 8'h55, 8'h00, 3'd6, 1'b0);
        applyStimulus(2'b00, 8'd2, 8'd3, 3'd0, 1'b0);
        applyStimulus(2'b10, 8'd100, 8'd9, 3'd2, 1'b1);

        // Reset mid-operation must abort with no completion or writeback.
        start = 1'b1;
        op = 2'b00;
        operand_a = 8'd17;
        operand_b = 8'd5;
        dest_addr = 3'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i <= 4) checkOutput($sformatf("abort_busy@N+%0d", i), 16'(busy), 16'd1);
            if (i == 5) checkOutput("abort_busy_cleared", 16'(busy), 16'd0);
            checkOutput($sformatf("abort_done@N+%0d", i), 16'(done), 16'd0);
            checkOutput($sformatf("abort_wb@N+%0d", i), 16'(wb_enable), 16'd0);
            reset = (i == 4);
            @(negedge clk);
        end
        reset = 1'b0;
        checkOutput("abort_result_cleared", 16'(result), 16'h00);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = (n % 6 == 5) ? 8'h00 : 8'($urandom);
            applyStimulus(2'($urandom), ra, rb, 3'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
